// File: rtl/i2c_cfg_writer.sv
// i2c_cfg_writer: walks an external table of register/data pairs and writes each pair
// to one I2C slave (DEV_ADDR, write only). Runs on the system clock with a quarter-bit
// clock-enable, checks every ACK, retries a NACKed entry up to MAX_RETRY times and
// leaves a released-bus gap after every STOP. Pads are open-drain: *_oe=1 pulls low.

module i2c_cfg_writer #(
    parameter int unsigned CLK_DIV   = 256,
    parameter int unsigned N_WRITES  = 6,
    parameter logic [6:0]  DEV_ADDR  = 7'h58,
    parameter int unsigned GAP_TICKS = 64,
    parameter int unsigned MAX_RETRY = 3,
    parameter int unsigned IDXW      = (N_WRITES > 1) ? $clog2(N_WRITES) : 1
) (
    input  logic            i_clk,
    input  logic            i_reset_n,
    input  logic            i_start,
    output logic [IDXW-1:0] o_idx,
    input  logic [7:0]      i_reg_addr,
    input  logic [7:0]      i_reg_data,
    input  logic            i_sda_in,
    output logic            o_sda_oe,
    output logic            o_scl_oe,
    output logic            o_busy,
    output logic            o_done,
    output logic            o_nack_err
);

    localparam int unsigned DIVW = $clog2(CLK_DIV);
    localparam int unsigned GAPW = (GAP_TICKS > 1) ? $clog2(GAP_TICKS) : 1;
    localparam int unsigned RETW = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
    localparam logic [4:0]  LAST_SLOT = 5'd26;

    typedef enum logic [2:0] {
        StIdle,
        StStart,
        StBits,
        StStop,
        StGap,
        StDone,
        StError
    } state_e;

    state_e          r_state;
    state_e          w_state_next;
    logic [DIVW-1:0] r_div;
    logic [1:0]      r_quarter;
    logic [4:0]      r_slot;
    logic [26:0]     r_shift;
    logic            r_nack;
    logic [RETW-1:0] r_retry;
    logic [GAPW-1:0] r_gap;
    logic [IDXW-1:0] r_idx;

    logic w_busy;
    logic w_accept;
    logic w_tick;
    logic w_in_frame;
    logic w_q_last;
    logic w_ack_slot;
    logic w_load;
    logic w_gap_end;
    logic w_last_entry;
    logic w_retry_left;

    assign w_busy       = (r_state == StStart) || (r_state == StBits) ||
                          (r_state == StStop)  || (r_state == StGap);
    // IDLE, DONE and ERROR are exactly the non-busy states, so start is accepted there
    assign w_accept     = i_start && !w_busy;
    assign w_tick       = w_busy && (r_div == DIVW'(CLK_DIV - 1));
    assign w_in_frame   = (r_state == StStart) || (r_state == StBits) || (r_state == StStop);
    assign w_q_last     = (r_quarter == 2'd3);
    assign w_ack_slot   = (r_slot == 5'd8) || (r_slot == 5'd17) || (r_slot == LAST_SLOT);
    assign w_load       = (r_state == StStart) && (r_quarter == 2'd0) && w_tick;
    assign w_gap_end    = (r_state == StGap) && w_tick && (r_gap == GAPW'(GAP_TICKS - 1));
    assign w_last_entry = (r_idx == IDXW'(N_WRITES - 1));
    // retry never exceeds MAX_RETRY, so inequality means more attempts remain
    assign w_retry_left = (r_retry != RETW'(MAX_RETRY));

    assign o_idx = r_idx;

    // State register
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic: each bus phase advances after its fourth quarter
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            StIdle, StDone, StError: begin
                if (w_accept) begin
                    w_state_next = StStart;
                end
            end
            StStart: begin
                if (w_tick && w_q_last) begin
                    w_state_next = StBits;
                end
            end
            StBits: begin
                if (w_tick && w_q_last && (r_slot == LAST_SLOT)) begin
                    w_state_next = StStop;
                end
            end
            StStop: begin
                if (w_tick && w_q_last) begin
                    w_state_next = StGap;
                end
            end
            StGap: begin
                if (w_gap_end) begin
                    if (!r_nack) begin
                        w_state_next = w_last_entry ? StDone : StStart;
                    end else begin
                        w_state_next = w_retry_left ? StStart : StError;
                    end
                end
            end
            default: w_state_next = StIdle;
        endcase
    end

    // Quarter-bit divider: runs only while busy, restarted when a run is accepted
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_div <= '0;
        end else if (w_accept || !w_busy || w_tick) begin
            r_div <= '0;
        end else begin
            r_div <= r_div + DIVW'(1);
        end
    end

    // Quarter, bit-slot and gap counters
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_quarter <= 2'd0;
            r_slot    <= 5'd0;
            r_gap     <= '0;
        end else begin
            if (!w_in_frame) begin
                r_quarter <= 2'd0;
            end else if (w_tick) begin
                r_quarter <= r_quarter + 2'd1;
            end

            if (r_state != StBits) begin
                r_slot <= 5'd0;
            end else if (w_tick && w_q_last) begin
                r_slot <= (r_slot == LAST_SLOT) ? 5'd0 : r_slot + 5'd1;
            end

            if (r_state != StGap || w_gap_end) begin
                r_gap <= '0;
            end else if (w_tick) begin
                r_gap <= r_gap + GAPW'(1);
            end
        end
    end

    // Frame shift register and per-attempt NACK flag
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_shift <= '1;
            r_nack  <= 1'b0;
        end else begin
            // ACK slots hold 1 so the master releases SDA for the slave
            if (w_load) begin
                r_shift <= {DEV_ADDR, 1'b0, 1'b1, i_reg_addr, 1'b1, i_reg_data, 1'b1};
            end else if ((r_state == StBits) && w_tick && w_q_last) begin
                r_shift <= {r_shift[25:0], 1'b1};
            end

            if (w_accept || w_load) begin
                r_nack <= 1'b0;
            end else if ((r_state == StBits) && w_tick && (r_quarter == 2'd2) &&
                         w_ack_slot && i_sda_in) begin
                r_nack <= 1'b1;
            end
        end
    end

    // Table index and retry count; idx only moves on GAP->START so the table can settle
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_idx   <= '0;
            r_retry <= '0;
        end else if (w_accept) begin
            r_idx   <= '0;
            r_retry <= '0;
        end else if (w_gap_end) begin
            if (!r_nack) begin
                if (!w_last_entry) begin
                    r_idx   <= r_idx + IDXW'(1);
                    r_retry <= '0;
                end
            end else if (w_retry_left) begin
                r_retry <= r_retry + RETW'(1);
            end
        end
    end

    // Output decode: pad drive and status follow state and quarter directly
    always_comb begin
        o_sda_oe   = 1'b0;
        o_scl_oe   = 1'b0;
        o_busy     = w_busy;
        o_done     = (r_state == StDone);
        o_nack_err = (r_state == StError);
        case (r_state)
            StStart: begin
                o_sda_oe = (r_quarter != 2'd0);
                o_scl_oe = (r_quarter == 2'd3);
            end
            StBits: begin
                o_sda_oe = ~r_shift[26];
                o_scl_oe = (r_quarter == 2'd0) || (r_quarter == 2'd3);
            end
            StStop: begin
                o_sda_oe = (r_quarter == 2'd0) || (r_quarter == 2'd1);
                o_scl_oe = (r_quarter == 2'd0);
            end
            default: begin
                o_sda_oe = 1'b0;
                o_scl_oe = 1'b0;
            end
        endcase
    end

endmodule
